// File: rtl/rotate_shift_if.sv
// rotate_shift_if: command/result handshake bundle for the rotate/shift pipeline.
interface rotate_shift_if #(
    parameter int ADDRESS_BITS = 3,
    parameter int TAG_BITS     = 4
);
    localparam int WIDTH = 2 ** ADDRESS_BITS;
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic [ADDRESS_BITS-1:0] in_amt;
    logic [WIDTH-1:0]        in_num;
    logic [TAG_BITS-1:0]     in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [TAG_BITS-1:0]     out_tag;
    logic                    out_err;
    logic                    out_zero;
    logic [15:0]             op_count;
    logic                    busy;
    modport master (
        output in_valid, in_op, in_amt, in_num, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err, out_zero, op_count, busy
    );
    modport slave (
        input  in_valid, in_op, in_amt, in_num, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err, out_zero, op_count, busy
    );
endinterface

// File: rtl/rotate_shift_pipe.sv
// rotate_shift_pipe: two-stage valid/ready pipeline around a left barrel rotator.
module rotate_shift_pipe #(
    parameter int ADDRESS_BITS = 3,
    parameter int TAG_BITS     = 4
) (
    input logic           clk,
    input logic           rst_n,
    rotate_shift_if.slave bus
);
    localparam int WIDTH = 2 ** ADDRESS_BITS;
    localparam logic [2:0] OP_ROTL = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_SAR  = 3'd4;
    logic                    s1_valid, s2_valid, s2_load, s2_err, illegal;
    logic [2:0]              s1_op;
    logic [ADDRESS_BITS-1:0] s1_amt, rot_amt;
    logic [WIDTH-1:0]        s1_num, s2_data, rot, keep_lo, keep_hi, result;
    logic [2*WIDTH-1:0]      dbl;
    logic [TAG_BITS-1:0]     s1_tag, s2_tag;
    logic [15:0]             count;
    // Right-going ops become a left rotate by the negated amount; masks then clear or sign-fill.
    always_comb begin
        s2_load = s1_valid && (!s2_valid || bus.out_ready);
        illegal = s1_op > OP_SAR;
        rot_amt = (s1_op == OP_ROTL || s1_op == OP_SHL) ? s1_amt : ~s1_amt + ADDRESS_BITS'(1);
        dbl     = {s1_num, s1_num} << rot_amt;
        rot     = dbl[2*WIDTH-1:WIDTH];
        keep_lo = {WIDTH{1'b1}} << s1_amt;
        keep_hi = {WIDTH{1'b1}} >> s1_amt;
        result  = illegal ? s1_num :
                  s1_op == OP_SHL ? rot & keep_lo :
                  s1_op == OP_SHR ? rot & keep_hi :
                  s1_op == OP_SAR ? (rot & keep_hi) | (~keep_hi & {WIDTH{s1_num[WIDTH-1]}}) :
                  rot;
    end
    assign bus.in_ready  = !s1_valid || s2_load;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_tag   = s2_tag;
    assign bus.out_err   = s2_err;
    assign bus.out_zero  = s2_data == '0;
    assign bus.op_count  = count;
    assign bus.busy      = s1_valid | s2_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_amt   <= '0;
            s1_num   <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
            s2_err   <= 1'b0;
            count    <= '0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (bus.in_ready && bus.in_valid) begin
                s1_op  <= bus.in_op;
                s1_amt <= bus.in_amt;
                s1_num <= bus.in_num;
                s1_tag <= bus.in_tag;
            end
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_data  <= result;
                s2_tag   <= s1_tag;
                s2_err   <= illegal;
            end else if (bus.out_ready) begin
                s2_valid <= 1'b0;
            end
            if (s2_valid && bus.out_ready) count <= count + 16'd1;
        end
    end
endmodule

// File: tb/tb_rotate_shift_pipe.sv
// tb_rotate_shift_pipe: directed and randomized checks of rotate_shift_pipe against an arithmetic model.
module tb_rotate_shift_pipe;
    localparam int N = 300;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rotate_shift_if bus ();
    rotate_shift_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int passed = 0;
    int k, cycles, stalls;
    logic [7:0] held;
    logic [3:0] got_tags[$];
    logic [2:0] c_op[N];
    logic [2:0] c_amt[N];
    logic [7:0] c_num[N];
    logic [3:0] c_tag[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Returns {err, data}; written from the op definitions, not the rotator datapath.
    function automatic logic [8:0] model(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] num);
        logic [7:0] r;
        int a;
        r = num;
        case (op)
            3'd0, 3'd1: begin
                a = (op == 3'd0) ? int'(amt) : (8 - int'(amt)) % 8;
                for (int i = 0; i < 8; i++) r[(i + a) % 8] = num[i];
                return {1'b0, r};
            end
            3'd2: return {1'b0, 8'(num << amt)};
            3'd3: return {1'b0, num >> amt};
            3'd4: return {1'b0, 8'($signed(num) >>> amt)};
            default: return {1'b1, num};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] amt, input logic [7:0] num, input logic [3:0] tg);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_amt   = amt;
        bus.in_num   = num;
        bus.in_tag   = tg;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run1(input string tag, input logic [2:0] op, input logic [2:0] amt, input logic [7:0] num,
                        input logic [3:0] tg, input logic [7:0] exp, input logic exp_err);
        @(negedge clk);
        drive(1'b1, op, amt, num, tg);
        bus.out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_early"}, bus.out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out_data, exp);
        chk({tag, "_tag"}, bus.out_tag, tg);
        chk({tag, "_err"}, bus.out_err, exp_err);
        chk({tag, "_zero"}, bus.out_zero, exp == 8'h00);
    endtask

    task automatic stream(input bit rnd, output int n_cycles, output int n_stalls);
        logic [12:0] q[$];
        logic [12:0] e;
        int sent, got;
        sent = 0;
        got = 0;
        n_cycles = 0;
        n_stalls = 0;
        while (got < N && n_cycles < 5000) begin
            @(negedge clk);
            n_cycles++;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < N) drive(1'b1, c_op[sent], c_amt[sent], c_num[sent], c_tag[sent]);
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("spurious_output", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("stream_data", bus.out_data, e[7:0]);
                    chk("stream_err", bus.out_err, e[8]);
                    chk("stream_tag", bus.out_tag, e[12:9]);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({c_tag[sent], model(c_op[sent], c_amt[sent], c_num[sent])});
                sent++;
            end else if (bus.in_valid) n_stalls++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_done", got, N);
    endtask

    initial begin
        drive(1'b0, 3'd0, 3'd0, 8'h00, 4'h0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_out_zero", bus.out_zero, 1);
        chk("rst_op_count", bus.op_count, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        run1("rotl81_1", 3'd0, 3'd1, 8'h81, 4'h1, 8'h03, 1'b0);
        run1("rotr81_1", 3'd1, 3'd1, 8'h81, 4'h2, 8'hC0, 1'b0);
        run1("rotr81_0", 3'd1, 3'd0, 8'h81, 4'h3, 8'h81, 1'b0);
        run1("shlff_3", 3'd2, 3'd3, 8'hFF, 4'h4, 8'hF8, 1'b0);
        run1("shrff_3", 3'd3, 3'd3, 8'hFF, 4'h5, 8'h1F, 1'b0);
        run1("sar80_3", 3'd4, 3'd3, 8'h80, 4'h6, 8'hF0, 1'b0);
        run1("sar40_3", 3'd4, 3'd3, 8'h40, 4'h7, 8'h08, 1'b0);
        run1("shr80_7", 3'd3, 3'd7, 8'h80, 4'h8, 8'h01, 1'b0);
        run1("illegal", 3'd5, 3'd2, 8'hA5, 4'h9, 8'hA5, 1'b1);
        run1("shl01_7", 3'd2, 3'd7, 8'h01, 4'hA, 8'h80, 1'b0);
        run1("shr01_1", 3'd3, 3'd1, 8'h01, 4'hB, 8'h00, 1'b0);
        @(negedge clk);
        chk("directed_op_count", bus.op_count, 11);

        do_reset();
        bus.out_ready = 1'b0;
        k = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) held = bus.out_data;
            drive(1'b1, 3'd0, 3'd0, 8'(k * 17), 4'(k));
            #1 if (bus.in_ready) k++;
        end
        @(negedge clk);
        chk("bp_accepted", k - 1, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_out_tag", bus.out_tag, 1);
        chk("bp_held_vs_sample", bus.out_data, held);
        chk("bp_held_value", bus.out_data, 8'd17);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got_tags.size() < 4; c++) begin
            if (k <= 4) drive(1'b1, 3'd0, 3'd0, 8'(k * 17), 4'(k));
            else bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                got_tags.push_back(bus.out_tag);
                chk("bp_drain_data", bus.out_data, 8'(int'(bus.out_tag) * 17));
            end
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("bp_drain_count", got_tags.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_order", (i < got_tags.size()) ? got_tags[i] : 4'hF, i + 1);
        chk("bp_op_count", bus.op_count, 4);

        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 3'd0, 8'h55, 4'h5);
        @(negedge clk);
        drive(1'b1, 3'd0, 3'd0, 8'h66, 4'h6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full_busy", bus.busy, 1);
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_op_count", bus.op_count, 0);
        chk("async_rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run1("post_rst", 3'd4, 3'd2, 8'h9C, 4'hC, 8'hE7, 1'b0);

        do_reset();
        for (int i = 0; i < N; i++) begin
            c_op[i]  = 3'($urandom_range(0, 7));
            c_amt[i] = 3'($urandom_range(0, 7));
            c_num[i] = 8'($urandom);
            c_tag[i] = 4'(i % 16);
        end
        stream(1'b0, cycles, stalls);
        chk("full_rate_cycles", cycles, N + 2);
        chk("full_rate_stalls", stalls, 0);
        chk("full_rate_op_count", bus.op_count, N);
        stream(1'b1, cycles, stalls);
        chk("rand_ready_op_count", bus.op_count, 2 * N);
        chk("rand_ready_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
